// File: rtl/pwm_capture.sv
// PWM decoder: reports high-time and period in clk cycles, valid 2 edges after the synchronized rise, no backpressure.
// Optional 3-sample majority glitch filter via `define PWM_CAPTURE_FILT_EN (+2 cycles latency).
module pwm_capture #(
  parameter int cwidth_g = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pwm_in,
  output logic [cwidth_g-1:0] duty_out,
  output logic [cwidth_g-1:0] period_out,
  output logic                valid,
  output logic                timeout
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [cwidth_g-1:0] cnt_max = '1;
  localparam logic [cwidth_g-1:0] one_c   = 1;
`ifdef PWM_CAPTURE_FILT_EN
  localparam logic [2:0] fill_c = 3'd4;
`else
  localparam logic [2:0] fill_c = 3'd2;
`endif

  state_t              state_q, state_d;
  logic                s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [2:0]          fill_q, fill_d;
  logic [cwidth_g-1:0] per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
  logic [cwidth_g-1:0] duty_q, duty_d, period_q, period_d;
  logic                valid_q, valid_d, timeout_q, timeout_d;
  logic                line, rise;

`ifdef PWM_CAPTURE_FILT_EN
  logic f1_q, f1_d, f2_q, f2_d, filt_q, filt_d;
  assign line = filt_q;
`else
  assign line = s2_q;
`endif

  assign rise = line & ~s3_q;

  always_comb begin
    state_d   = state_q;
    s1_d      = pwm_in;
    s2_d      = s1_q;
    s3_d      = line;
    fill_d    = (fill_q == fill_c) ? fill_q : fill_q + 3'd1;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    duty_d    = duty_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
`ifdef PWM_CAPTURE_FILT_EN
    f1_d   = s2_q;
    f2_d   = f1_q;
    filt_d = (s2_q & f1_q) | (s2_q & f2_q) | (f1_q & f2_q);
`endif
    case (state_q)
      // Wait until the sync pipeline reflects the real line, so a line
      // already high at reset release is not mistaken for a fresh rise.
      IDLE: begin
        if (fill_q == fill_c && !line) state_d = ARM;
      end
      ARM: begin
        if (rise) begin
          state_d   = MEASURE;
          per_cnt_d = one_c;
          hi_cnt_d  = one_c;
        end
      end
      MEASURE: begin
        if (rise) begin
          duty_d    = hi_cnt_q;
          period_d  = per_cnt_q;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          per_cnt_d = one_c;
          hi_cnt_d  = one_c;
        end else if (per_cnt_q == cnt_max) begin
          duty_d    = line ? cnt_max : '0;
          period_d  = '0;
          valid_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          per_cnt_d = per_cnt_q + one_c;
          if (hi_cnt_q != cnt_max && line) hi_cnt_d = hi_cnt_q + one_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      fill_q    <= '0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      duty_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
`ifdef PWM_CAPTURE_FILT_EN
      f1_q      <= 1'b0;
      f2_q      <= 1'b0;
      filt_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      fill_q    <= fill_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
`ifdef PWM_CAPTURE_FILT_EN
      f1_q      <= f1_d;
      f2_q      <= f2_d;
      filt_q    <= filt_d;
`endif
    end
  end

  assign duty_out   = duty_q;
  assign period_out = period_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: expected reports are queued as periods are driven and matched on each valid pulse.
module tb_pwm_capture;

  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          pwm_in;
  logic [CW-1:0] duty_out, period_out;
  logic          valid, timeout;

  typedef struct {
    int duty;
    int period;
    int tmo;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   prev_p = 0, prev_h = 0;
  bit   have_prev = 0;

  pwm_capture #(.cwidth_g(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .pwm_in    (pwm_in),
    .duty_out  (duty_out),
    .period_out(period_out),
    .valid     (valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int d, input int p, input int t);
    exp_t e;
    e.duty = d;
    e.period = p;
    e.tmo = t;
    sb.push_back(e);
  endtask

  // The rise that starts this period closes the previous one.
  task automatic drive_period(input int p, input int h);
    if (have_prev) push_exp(prev_h, prev_p, 0);
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      pwm_in = (i < h);
    end
    prev_p = p;
    prev_h = h;
    have_prev = 1;
  endtask

  task automatic drive_level(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pwm_in = v;
    end
  endtask

  always @(negedge clk) begin
    if (!reset && valid) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("duty", int'(duty_out), e.duty);
        check_eq("period", int'(period_out), e.period);
        check_eq("timeout", int'(timeout), e.tmo);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    pwm_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pwm_in = ~pwm_in;
      check_eq("rst_duty", int'(duty_out), 0);
      check_eq("rst_period", int'(period_out), 0);
      check_eq("rst_valid", int'(valid), 0);
      check_eq("rst_timeout", int'(timeout), 0);
    end
    @(negedge clk);
    pwm_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    drive_level(1'b0, 5);

    for (int i = 0; i < 5; i++) drive_period(10, 3);

    // 8-bit generator loopback: period 256, high = sig_in.
    for (int i = 0; i < 3; i++) drive_period(256, 64);
    for (int i = 0; i < 2; i++) drive_period(256, 192);

    push_exp(0, 0, 1);
    have_prev = 0;
    drive_level(1'b0, 1100);
    for (int i = 0; i < 3; i++) drive_period(12, 5);
    drive_level(1'b0, 5);
    check_eq("tmo_cleared", int'(timeout), 0);
    check_eq("sb_drained_1", sb.size(), 0);

    // Reset with the line high: the partial first period must be discarded.
    @(negedge clk);
    pwm_in = 1'b1;
    reset  = 1'b1;
    have_prev = 0;
    drive_level(1'b1, 3);
    check_eq("rst2_valid", int'(valid), 0);
    check_eq("rst2_duty", int'(duty_out), 0);
    @(negedge clk);
    reset = 1'b0;
    drive_level(1'b1, 5);
    drive_level(1'b0, 4);
    for (int i = 0; i < 3; i++) drive_period(8, 4);

`ifdef PWM_CAPTURE_FILT_EN
    push_exp(prev_h, prev_p, 0);
    drive_level(1'b1, 3);
    drive_level(1'b0, 3);
    drive_level(1'b1, 1);
    drive_level(1'b0, 3);
    prev_p = 10;
    prev_h = 3;
    for (int i = 0; i < 2; i++) drive_period(10, 3);
    drive_level(1'b1, 1);
    push_exp(3, 10, 0);
`endif

    drive_level(1'b0, 20);
    check_eq("sb_drained_2", sb.size(), 0);
    check_eq("tmo_final", int'(timeout), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
